// File: rtl/dtc_vote_accum_if.sv
// Handshake bundle between the classifier stage, the vote accumulator and its consumer.
interface dtc_vote_accum_if #(
  parameter int unsigned OUT_W = 10,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] inp;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] outp;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, inp, flush, out_ready,
    input  in_ready, out_valid, outp, out_count
  );

  modport slave (
    input  in_valid, inp, flush, out_ready,
    output in_ready, out_valid, outp, out_count
  );
endinterface

// File: rtl/dtc_vote_accum.sv
// Windowed per-bit majority vote over classifier output vectors; one voted
// vector per full window (2**WIN_LOG2 samples) or per early flush.
module dtc_vote_accum #(
  parameter int unsigned OUT_W    = 10,
  parameter int unsigned WIN_LOG2 = 3,
  parameter int unsigned CNT_W    = WIN_LOG2 + 1
) (
  input logic              clk,
  input logic              rst,
  dtc_vote_accum_if.slave  bus
);

  localparam int unsigned WIN = 1 << WIN_LOG2;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [OUT_W];
  logic [CNT_W-1:0] cnt_d [OUT_W];
  logic [CNT_W-1:0] cnt_acc [OUT_W];
  logic [CNT_W-1:0] n_q, n_d, n_acc;
  logic [OUT_W-1:0] outp_q, outp_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  // Next-state, counter update and vote decision.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    outp_d      = outp_q;
    out_count_d = out_count_q;

    accept = bus.in_valid & in_ready_q;
    for (int i = 0; i < int'(OUT_W); i++) begin
      cnt_acc[i] = cnt_q[i] + CNT_W'(accept & bus.inp[i]);
    end
    n_acc = n_q + CNT_W'(accept);

    case (state_q)
      ACCUM: begin
        cnt_d = cnt_acc;
        n_d   = n_acc;
        if ((accept && (n_acc == CNT_W'(WIN))) || (bus.flush && (n_acc != '0))) begin
          state_d = EMIT;
          // Strict majority: ties vote 0; one extra bit so 2*cnt cannot wrap.
          for (int i = 0; i < int'(OUT_W); i++) begin
            outp_d[i] = {cnt_acc[i], 1'b0} > {1'b0, n_acc};
          end
          out_count_d = n_acc;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          n_d     = '0;
          for (int i = 0; i < int'(OUT_W); i++) begin
            cnt_d[i] = '0;
          end
        end
      end
      default: state_d = ACCUM;
    endcase

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      n_q         <= '0;
      outp_q      <= '0;
      out_count_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(OUT_W); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      outp_q      <= outp_d;
      out_count_q <= out_count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < int'(OUT_W); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.outp      = outp_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Bench for dtc_vote_accum: vector table plus scoreboard of expected windows.
module tb_dtc_vote_accum;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dtc_vote_accum_if #(.OUT_W(10), .CNT_W(4)) bus ();

  dtc_vote_accum #(.OUT_W(10), .WIN_LOG2(3), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [9:0] inp;
    logic       flush;
    logic       close;
    logic [9:0] exp_outp;
    logic [3:0] exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [9:0] outp;
    logic [3:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void add(input logic [9:0] inp, input logic flush, input logic close,
                              input logic [9:0] eo, input logic [3:0] ec);
    vec_t v;
    v.inp = inp; v.flush = flush; v.close = close; v.exp_outp = eo; v.exp_cnt = ec;
    tbl.push_back(v);
  endfunction

  // Called at a negedge; returns at the negedge after the sample is accepted.
  task automatic send(input logic [9:0] d, input logic fl, input logic close,
                      input logic [9:0] eo, input logic [3:0] ec);
    int waited = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.inp      = d;
    bus.flush    = fl;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    if (close) begin
      e.outp = eo; e.cnt = ec;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  // Scoreboard: compare every completed output handshake against the queue.
  always @(negedge clk) begin
    #1;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_emission", 32'(bus.outp), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_outp", 32'(bus.outp), 32'(e.outp));
        chk("sb_count", 32'(bus.out_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.inp       = 10'h3FF;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held two cycles with in_valid asserted.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_outp", 32'(bus.outp), 32'd0);
      chk("rst_out_count", 32'(bus.out_count), 32'd0);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Full window, tie window, flush window.
    for (int i = 0; i < 8; i++) add(10'b1000000110, 1'b0, i == 7, 10'b1000000110, 4'd8);
    for (int i = 0; i < 4; i++) add(10'b1111111111, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) add(10'b0000000000, 1'b0, i == 3, 10'b0000000000, 4'd8);
    add(10'b1100000001, 1'b0, 1'b0, '0, '0);
    add(10'b1100000001, 1'b0, 1'b0, '0, '0);
    add(10'b0000000011, 1'b1, 1'b1, 10'b1100000001, 4'd3);

    foreach (tbl[k]) begin
      send(tbl[k].inp, tbl[k].flush, tbl[k].close, tbl[k].exp_outp, tbl[k].exp_cnt);
      if (tbl[k].close) begin
        chk("close_out_valid", 32'(bus.out_valid), 32'd1);
        chk("close_in_ready", 32'(bus.in_ready), 32'd0);
        chk("close_outp", 32'(bus.outp), 32'(tbl[k].exp_outp));
        chk("close_count", 32'(bus.out_count), 32'(tbl[k].exp_cnt));
      end
    end
    @(negedge clk);

    // Flush with an empty window is ignored.
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("empty_flush_no_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end

    // Backpressure: result holds while out_ready is low.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send((i < 5) ? 10'h155 : 10'h2AA, 1'b0, i == 7, 10'h155, 4'd8);
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_outp", 32'(bus.outp), 32'h155);
      chk("bp_count", 32'(bus.out_count), 32'd8);
      bus.in_valid = (c % 2) == 0;
      bus.inp      = 10'h3FF;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_hold_outp", 32'(bus.outp), 32'h155);

    // Fresh window after backpressure must start from cleared counters.
    for (int i = 0; i < 8; i++) send(10'h3C0, 1'b0, i == 7, 10'h3C0, 4'd8);
    @(negedge clk);

    // Reset mid-window discards the partial window.
    for (int i = 0; i < 5; i++) send(10'h3FF, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_outp", 32'(bus.outp), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 8; i++) send(10'b0000000001, 1'b0, i == 7, 10'b0000000001, 4'd8);
    chk("midrst_close_valid", 32'(bus.out_valid), 32'd1);
    chk("midrst_outp_final", 32'(bus.outp), 32'h001);
    repeat (3) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dtc_vote_accum.md
# dtc_vote_accum

Windowed majority-vote accumulator that sits directly downstream of a decision-tree classifier stage. Each accepted 10-bit classifier output vector adds to a per-bit counter. When a window of 2**WIN_LOG2 samples closes, or an early flush closes it, the block emits a 10-bit vector holding the strict per-bit majority. It smooths the per-sample tree decisions into one decision per window for the consuming logic.

## Interface
- OUT_W, 10, width of the classifier output vector and of the voted result
- WIN_LOG2, 3, log2 of the full window length (default window = 8 samples)
- CNT_W, WIN_LOG2+1, counter width; holds 0..2**WIN_LOG2 inclusive
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  inp carries a classifier vector
- in_ready  output  1  block accepts inp this cycle
- inp  input  OUT_W  classifier output vector
- flush  input  1  close the current partial window early
- out_valid  output  1  voted result is available
- out_ready  input  1  consumer takes the result
- outp  output  OUT_W  voted majority vector
- out_count  output  CNT_W  number of samples in the emitted window

## Operation
- The FSM has two states: ACCUM and EMIT.
- The block holds per-bit counters cnt[i] (CNT_W bits each) and a sample counter n (CNT_W bits).

ACCUM state:
- in_ready = 1 and out_valid = 0.
- Accept condition: in_valid & in_ready. On accept, every cnt[i] += inp[i] and n += 1.
- Full-window close: if the accept raises n to 2**WIN_LOG2, the FSM moves to EMIT.
- Flush close: flush with n_next >= 1 moves the FSM to EMIT. n_next includes a sample accepted in the same cycle.
- Flush with n = 0 and no accept is ignored. The FSM stays in ACCUM.
- On the transition to EMIT, the result is registered:
  - outp[i] = 1 iff 2*cnt_next[i] > n_next. The comparison is CNT_W+1 bits wide.
  - A tie yields 0.
  - out_count = n_next.

EMIT state:
- out_valid = 1 and in_ready = 0. An in_valid during EMIT is not consumed; inp is ignored.
- outp and out_count are stable until out_ready = 1.
- On out_valid & out_ready, all cnt[i] and n clear to 0 and the FSM returns to ACCUM.
- flush is ignored in EMIT.
- outp and out_count keep the last emitted values after the handshake; only out_valid drops.

Reset:
- While rst = 1: FSM = ACCUM, cnt and n = 0, outp = 0, out_count = 0, out_valid = 0, in_ready = 0.
- in_ready rises in the first cycle after rst deasserts.

Reset mid-operation:
- rst in any state discards the partial window or the pending result with no emission.

## Timing
- Latency: last sample accepted (or flush) in cycle T gives out_valid = 1 from cycle T+1.
- Minimum throughput: one full window per 2**WIN_LOG2 + 1 cycles. There is a mandatory one-cycle EMIT bubble with in_ready = 0.
- All outputs are registered or decoded from the FSM state. There are no combinational paths from inp, in_valid or out_ready to any output.
- Overflow is impossible: n never exceeds 2**WIN_LOG2 because the FSM leaves ACCUM on the accept that reaches it.

## Test plan
1. Reset: hold rst for 2 cycles with in_valid = 1.
   - During reset: in_ready = 0, out_valid = 0, outp = 0, out_count = 0.
   - First cycle after reset: in_ready = 1.
2. Full window: 8 back-to-back samples of 10'b1000000110.
   - out_valid = 1 in the cycle after the 8th accept, with outp = 10'b1000000110 and out_count = 8.
   - in_ready = 0 during that cycle.
3. Tie: 4 samples of 10'b1111111111, then 4 samples of 10'b0000000000.
   - outp = 10'b0000000000, out_count = 8.
4. Flush: samples A, A, B with A = 10'b1100000001 and B = 10'b0000000011, flush asserted with B.
   - outp = 10'b1100000001, out_count = 3.
   - A separate flush with n = 0 must produce no out_valid.
5. Backpressure: hold out_ready = 0 for 5 cycles while in EMIT and pulse in_valid.
   - outp, out_count and out_valid stay stable; in_ready = 0.
   - After out_ready = 1: out_valid drops, and the next 8 samples form a fresh window with the counters starting at 0.
6. Reset mid-window: accept 5 samples of 10'b1111111111, then apply 1 cycle of rst, then 8 samples of 10'b0000000001.
   - outp = 10'b0000000001, out_count = 8.
   - No emission occurs for the discarded partial window.
